reg_bus_ctrl: RTL

Request-side sequencer for the 16-entry × 16-bit register-file block on the shared tri-state data bus. It accepts read/write requests through a valid/ready handshake, buffers them in a small FIFO, and drives the register file's `W`, `ON`, `ADDR` and `Mem_Bus` signals with the correct per-operation cycle sequence. It captures read data from the bus and returns it on a held response port with backpressure.

---
 rtl/reg_bus_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/reg_bus_ctrl.sv
// Request sequencer for a 16x16 register file on a shared tri-state bus.
// Buffers requests in a FIFO, drives W/ON/ADDR/Mem_Bus, and holds read data on a valid/ready port.
module reg_bus_ctrl #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              W,
  output logic              ON,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] Mem_Bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Encoding puts ON on bit 0 and W (bus drive) on bit 1 so both are plain flop outputs.
  typedef enum logic [2:0] {
    IDLE = 3'b000,
    RD1  = 3'b001,
    WR   = 3'b011,
    RD2  = 3'b101
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wdata [FIFO_DEPTH];
  logic              fifo_write [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;

  logic              push, pop, empty, full, rsp_free;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;

  assign empty      = (count == '0);
  assign full       = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign req_ready  = !RST && !full;
  assign push       = req_valid && req_ready;
  assign head_write = fifo_write[rd_ptr];
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_wdata = fifo_wdata[rd_ptr];
  // A response being consumed this cycle frees the slot for the next read's RD1.
  assign rsp_free   = !rsp_valid || rsp_ready;

  assign ON      = state[0];
  assign W       = state[1];
  assign ADDR    = op_addr;
  assign Mem_Bus = state[1] ? op_wdata : {DATA_W{1'bz}};

  always_comb begin
    state_nxt = IDLE;
    pop       = 1'b0;
    unique case (state)
      RD1: state_nxt = RD2;
      default: begin
        if (!empty) begin
          if (head_write) begin
            pop       = 1'b1;
            state_nxt = WR;
          end else if (rsp_free && (state != RD2)) begin
            pop       = 1'b1;
            state_nxt = RD1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      op_addr   <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (pop) op_addr <= head_addr;
      if (state == RD2) begin
        rsp_data  <= Mem_Bus;
        rsp_valid <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Datapath registers: storage and write operand need no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= req_addr;
      fifo_wdata[wr_ptr] <= req_wdata;
      fifo_write[wr_ptr] <= req_write;
    end
    if (pop && head_write) op_wdata <= head_wdata;
  end

endmodule
